// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves MIPS-style conditional branches and J/JR jumps from the execute-stage
// comparator flags. It emits a registered redirect to the PC module only on a
// mispredict or an unconditional jump. It writes back the link address for the
// *AL/JAL/JALR forms. It trains a table of 2-bit saturating counters that fetch
// reads combinationally, and keeps saturating resolve/mispredict statistics.
//
// Ports
//   clk, rst               clock; synchronous active-low reset
//   in_valid / in_ready    resolve request handshake
//   mode[3:0]              branch mode code; mode[4] = link flag
//   pcAddress              already-incremented PC of the branch
//   branchAddressOffset    signed word offset
//   jumpAddress            J-type 26-bit target field
//   jumpRegisterAddress    JR target
//   resultZero/Negative/Positive, fpCondition   condition inputs
//   predTaken              prediction fetch made for this branch
//   redirect_valid/ready   redirect handshake toward the PC module
//   branchTo               redirect target (held stable while pending)
//   link_write, link_address   one-cycle link-register write
//   lookup_pc, lookup_taken    fetch-side predictor read port
//   resolved_count, mispredict_count   saturating statistics
module branch_resolve_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int PRED_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            mode,
  input  logic [ADDR_WIDTH-1:0] pcAddress,
  input  logic [15:0]           branchAddressOffset,
  input  logic [25:0]           jumpAddress,
  input  logic [ADDR_WIDTH-1:0] jumpRegisterAddress,
  input  logic                  resultZero,
  input  logic                  resultNegative,
  input  logic                  resultPositive,
  input  logic                  fpCondition,
  input  logic                  predTaken,
  output logic                  redirect_valid,
  input  logic                  redirect_ready,
  output logic [ADDR_WIDTH-1:0] branchTo,
  output logic                  link_write,
  output logic [ADDR_WIDTH-1:0] link_address,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  lookup_taken,
  output logic [CNT_WIDTH-1:0]  resolved_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(PRED_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP4 = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
  localparam logic [ADDR_WIDTH-1:0] PC_STEP8 = {{(ADDR_WIDTH-4){1'b0}}, 4'b1000};
  localparam logic [ADDR_WIDTH-1:0] HI_MASK  = {ADDR_WIDTH{1'b1}} << 28;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // 2-bit saturating counter step toward taken (up) or not-taken.
  function automatic logic [1:0] sat2_next(input logic [1:0] c, input logic up);
    logic [1:0] r;
    if (up) begin
      r = (c == 2'b11) ? 2'b11 : c + 2'b01;
    end else begin
      r = (c == 2'b00) ? 2'b00 : c - 2'b01;
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   branch_to_q, branch_to_d;
  logic                    link_write_q, link_write_d;
  logic [ADDR_WIDTH-1:0]   link_addr_q, link_addr_d;
  logic [CNT_WIDTH-1:0]    resolved_q, resolved_d;
  logic [CNT_WIDTH-1:0]    mispred_q, mispred_d;
  logic [1:0]              pred_q [PRED_DEPTH];

  logic                    is_cond_s, is_jump_s, link_ok_s, taken_s;
  logic                    accept_s, mispred_s, redir_req_s;
  logic [ADDR_WIDTH-1:0]   br_target_s, fall_s, j_target_s, target_s;
  logic [IDX_W-1:0]        upd_idx_s, look_idx_s;
  logic                    pred_we_s;
  logic [1:0]              pred_new_s;
  logic                    unused_s;

  assign redirect_valid   = (state_q == HOLD);
  assign in_ready         = !redirect_valid || redirect_ready;
  assign accept_s         = in_valid && in_ready;
  assign branchTo         = branch_to_q;
  assign link_write       = link_write_q;
  assign link_address     = link_addr_q;
  assign resolved_count   = resolved_q;
  assign mispredict_count = mispred_q;

  assign br_target_s = pcAddress + {{(ADDR_WIDTH-18){branchAddressOffset[15]}}, branchAddressOffset, 2'b00};
  assign fall_s      = pcAddress + PC_STEP4;
  // Keep the PC region bits above bit 27 and splice in the 28-bit jump target.
  assign j_target_s  = (pcAddress & HI_MASK) | ADDR_WIDTH'({jumpAddress, 2'b00});

  assign upd_idx_s    = pcAddress[2 +: IDX_W];
  assign look_idx_s   = lookup_pc[2 +: IDX_W];
  assign lookup_taken = pred_q[look_idx_s][1];
  assign unused_s     = ^lookup_pc;

  // Decode the mode code into branch class, link eligibility and the taken condition.
  always_comb begin
    is_cond_s = 1'b0;
    is_jump_s = 1'b0;
    link_ok_s = 1'b0;
    taken_s   = 1'b0;
    case (mode[3:0])
      4'h0: begin is_cond_s = 1'b1; link_ok_s = 1'b1;
                  taken_s = resultNegative && !resultZero && !resultPositive; end
      4'h1: begin is_cond_s = 1'b1; link_ok_s = 1'b1;
                  taken_s = (resultZero || resultPositive) && !resultNegative; end
      4'h3: begin is_cond_s = 1'b1;
                  taken_s = resultZero && !resultNegative && !resultPositive; end
      4'h4: begin is_cond_s = 1'b1;
                  taken_s = resultPositive && !resultZero && !resultNegative; end
      4'h5: begin is_cond_s = 1'b1;
                  taken_s = !resultPositive && (resultZero || resultNegative); end
      4'h6: begin is_cond_s = 1'b1;
                  taken_s = (resultPositive || resultNegative) && !resultZero; end
      4'h7: begin is_cond_s = 1'b1; taken_s = fpCondition; end
      4'h8: begin is_cond_s = 1'b1; taken_s = !fpCondition; end
      4'h9: begin is_jump_s = 1'b1; link_ok_s = 1'b1; taken_s = 1'b1; end
      4'hA: begin is_jump_s = 1'b1; link_ok_s = 1'b1; taken_s = 1'b1; end
      default: taken_s = 1'b0;
    endcase
  end

  // Mispredict detection and redirect target selection.
  always_comb begin
    mispred_s   = is_cond_s && (taken_s != predTaken);
    redir_req_s = is_jump_s || mispred_s;
    if (is_jump_s) begin
      target_s = (mode[3:0] == 4'h9) ? j_target_s : jumpRegisterAddress;
    end else begin
      target_s = taken_s ? br_target_s : fall_s;
    end
  end

  // Next-state for the redirect FSM, output registers, predictor and statistics.
  always_comb begin
    state_d      = state_q;
    branch_to_d  = branch_to_q;
    link_write_d = 1'b0;
    link_addr_d  = link_addr_q;
    resolved_d   = resolved_q;
    mispred_d    = mispred_q;
    pred_we_s    = 1'b0;
    pred_new_s   = sat2_next(pred_q[upd_idx_s], taken_s);

    case (state_q)
      IDLE: begin
        if (accept_s && redir_req_s) state_d = HOLD;
        else                         state_d = IDLE;
      end
      HOLD: begin
        // A request accepted here implies redirect_ready was high.
        if (redirect_ready) state_d = (accept_s && redir_req_s) ? HOLD : IDLE;
        else                state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase

    if (accept_s && redir_req_s) branch_to_d = target_s;
    else                         branch_to_d = branch_to_q;

    if (accept_s && link_ok_s && mode[4]) begin
      link_write_d = 1'b1;
      link_addr_d  = pcAddress + PC_STEP8;
    end else begin
      link_write_d = 1'b0;
    end

    if (accept_s && is_cond_s) begin
      pred_we_s = 1'b1;
      if (resolved_q != CNT_MAX) resolved_d = resolved_q + CNT_ONE;
      else                       resolved_d = resolved_q;
      if (mispred_s && (mispred_q != CNT_MAX)) mispred_d = mispred_q + CNT_ONE;
      else                                     mispred_d = mispred_q;
    end else begin
      pred_we_s = 1'b0;
    end
  end

  // State, output and statistics registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      branch_to_q  <= {ADDR_WIDTH{1'b0}};
      link_write_q <= 1'b0;
      link_addr_q  <= {ADDR_WIDTH{1'b0}};
      resolved_q   <= {CNT_WIDTH{1'b0}};
      mispred_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      branch_to_q  <= branch_to_d;
      link_write_q <= link_write_d;
      link_addr_q  <= link_addr_d;
      resolved_q   <= resolved_d;
      mispred_q    <= mispred_d;
    end
  end

  // Predictor table; every entry resets to weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PRED_DEPTH; i++) pred_q[i] <= 2'b01;
    end else if (pred_we_s) begin
      pred_q[upd_idx_s] <= pred_new_s;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  mode;
  logic [31:0] pcAddress;
  logic [15:0] branchAddressOffset;
  logic [25:0] jumpAddress;
  logic [31:0] jumpRegisterAddress;
  logic        resultZero, resultNegative, resultPositive, fpCondition, predTaken;
  logic        redirect_valid, redirect_ready;
  logic [31:0] branchTo;
  logic        link_write;
  logic [31:0] link_address;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic [15:0] resolved_count, mispredict_count;

  int n_assert = 0;
  int n_fail   = 0;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .pcAddress(pcAddress), .branchAddressOffset(branchAddressOffset),
    .jumpAddress(jumpAddress), .jumpRegisterAddress(jumpRegisterAddress),
    .resultZero(resultZero), .resultNegative(resultNegative),
    .resultPositive(resultPositive), .fpCondition(fpCondition), .predTaken(predTaken),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .branchTo(branchTo), .link_write(link_write), .link_address(link_address),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .resolved_count(resolved_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one cycle (flags as {Z,N,P}).
  task automatic req(input logic [4:0] m, input logic [31:0] pc, input logic [15:0] off,
                     input logic [25:0] ja, input logic [31:0] jr, input logic [2:0] znp,
                     input logic fp, input logic pt);
    in_valid = 1'b1; mode = m; pcAddress = pc; branchAddressOffset = off;
    jumpAddress = ja; jumpRegisterAddress = jr;
    {resultZero, resultNegative, resultPositive} = znp;
    fpCondition = fp; predTaken = pt;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; mode = 5'h02; pcAddress = 32'h0;
    branchAddressOffset = 16'h0; jumpAddress = 26'h0; jumpRegisterAddress = 32'h0;
    resultZero = 1'b0; resultNegative = 1'b0; resultPositive = 1'b0;
    fpCondition = 1'b0; predTaken = 1'b0; redirect_ready = 1'b1; lookup_pc = 32'h40;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    check("rst_lookup", lookup_taken, 1'b0);
    check("rst_rv", redirect_valid, 1'b0);
    check("rst_bto", branchTo, 32'h0);
    check("rst_lw", link_write, 1'b0);
    check("rst_la", link_address, 32'h0);
    check("rst_res", resolved_count, 16'd0);
    check("rst_mis", mispredict_count, 16'd0);
    check("rst_rdy", in_ready, 1'b1);

    // BEQ taken, predicted not-taken -> redirect to 0x1000 - 16
    req(5'h03, 32'h1000, 16'hFFFC, 26'h0, 32'h0, 3'b100, 1'b0, 1'b0);
    check("beq_rv", redirect_valid, 1'b1);
    check("beq_bto", branchTo, 32'h0000_0FF0);
    check("beq_res", resolved_count, 16'd1);
    check("beq_mis", mispredict_count, 16'd1);
    check("beq_lw", link_write, 1'b0);

    // BNE not-taken, predicted taken -> fall-through (back-to-back with HOLD)
    req(5'h06, 32'h2000, 16'h0010, 26'h0, 32'h0, 3'b100, 1'b0, 1'b1);
    check("bne_rv", redirect_valid, 1'b1);
    check("bne_bto", branchTo, 32'h0000_2004);
    check("bne_mis", mispredict_count, 16'd2);

    // Same BNE correctly predicted -> no redirect
    req(5'h06, 32'h2000, 16'h0010, 26'h0, 32'h0, 3'b100, 1'b0, 1'b0);
    check("bne2_rv", redirect_valid, 1'b0);
    check("bne2_bto", branchTo, 32'h0000_2004);
    check("bne2_res", resolved_count, 16'd3);
    check("bne2_mis", mispredict_count, 16'd2);

    // JAL
    req(5'h19, 32'hA000_0010, 16'h0, 26'h0000100, 32'h0, 3'b000, 1'b0, 1'b1);
    check("jal_rv", redirect_valid, 1'b1);
    check("jal_bto", branchTo, 32'hA000_0400);
    check("jal_lw", link_write, 1'b1);
    check("jal_la", link_address, 32'hA000_0018);
    check("jal_res", resolved_count, 16'd3);
    check("jal_mis", mispredict_count, 16'd2);
    tick();
    check("jal_lw_pulse", link_write, 1'b0);
    check("jal_rv_done", redirect_valid, 1'b0);

    // NONE with link flag: consumed, no effect
    req(5'h12, 32'h4000, 16'h0, 26'h0, 32'h0, 3'b100, 1'b0, 1'b1);
    check("none_rv", redirect_valid, 1'b0);
    check("none_lw", link_write, 1'b0);
    check("none_res", resolved_count, 16'd3);

    // BLTZAL not taken, predicted not-taken: link still written
    req(5'h10, 32'h0500, 16'h0, 26'h0, 32'h0, 3'b001, 1'b0, 1'b0);
    check("bltzal_rv", redirect_valid, 1'b0);
    check("bltzal_lw", link_write, 1'b1);
    check("bltzal_la", link_address, 32'h0000_0508);
    check("bltzal_res", resolved_count, 16'd4);

    // BEQ with link flag: link ignored
    req(5'h13, 32'h0600, 16'h0, 26'h0, 32'h0, 3'b010, 1'b0, 1'b0);
    check("beql_lw", link_write, 1'b0);
    check("beql_la", link_address, 32'h0000_0508);
    check("beql_res", resolved_count, 16'd5);

    // Predictor training at 0x44: 01 -> 10 -> 11 -> 11
    lookup_pc = 32'h44;
    #1;
    check("pred_init", lookup_taken, 1'b0);
    req(5'h04, 32'h44, 16'h0, 26'h0, 32'h0, 3'b001, 1'b0, 1'b1);
    check("pred_t1", lookup_taken, 1'b1);
    req(5'h04, 32'h44, 16'h0, 26'h0, 32'h0, 3'b001, 1'b0, 1'b1);
    req(5'h04, 32'h44, 16'h0, 26'h0, 32'h0, 3'b001, 1'b0, 1'b1);
    check("pred_t3", lookup_taken, 1'b1);
    // Not-taken: 11 -> 10 -> 01 -> 00 -> 00
    req(5'h04, 32'h44, 16'h0, 26'h0, 32'h0, 3'b100, 1'b0, 1'b0);
    check("pred_n1", lookup_taken, 1'b1);
    req(5'h04, 32'h44, 16'h0, 26'h0, 32'h0, 3'b100, 1'b0, 1'b0);
    check("pred_n2", lookup_taken, 1'b0);
    req(5'h04, 32'h44, 16'h0, 26'h0, 32'h0, 3'b100, 1'b0, 1'b0);
    req(5'h04, 32'h44, 16'h0, 26'h0, 32'h0, 3'b100, 1'b0, 1'b0);
    check("pred_n4", lookup_taken, 1'b0);
    check("pred_res", resolved_count, 16'd12);
    check("pred_mis", mispredict_count, 16'd2);
    check("pred_rv", redirect_valid, 1'b0);

    // JR stalled by redirect_ready=0
    redirect_ready = 1'b0;
    req(5'h0A, 32'h3000, 16'h0, 26'h0, 32'h1234_5678, 3'b000, 1'b0, 1'b0);
    check("jr_rv", redirect_valid, 1'b1);
    check("jr_bto", branchTo, 32'h1234_5678);
    check("jr_rdy", in_ready, 1'b0);
    // Second request (J) presented and held
    in_valid = 1'b1; mode = 5'h09; pcAddress = 32'h3100; jumpAddress = 26'h40;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_bto", branchTo, 32'h1234_5678);
      check("hold_rv", redirect_valid, 1'b1);
      check("hold_rdy", in_ready, 1'b0);
    end
    redirect_ready = 1'b1;
    #1;
    check("rel_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    redirect_ready = 1'b0;
    check("j_rv", redirect_valid, 1'b1);
    check("j_bto", branchTo, 32'h0000_0100);
    check("j_res", resolved_count, 16'd12);
    tick();
    check("j_hold", redirect_valid, 1'b1);

    // Reset mid-HOLD
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_rv", redirect_valid, 1'b0);
    check("mid_rst_bto", branchTo, 32'h0);
    check("mid_rst_res", resolved_count, 16'd0);
    check("mid_rst_pred", lookup_taken, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
